// File: rtl/duty_ramp.sv
// Duty slew limiter feeding the PWM stage: steps the applied duty toward the latched target.
// Optional DUTY_RAMP_BYPASS_EN adds i_bypass, which applies an accepted target in one write.
module duty_ramp #(
  parameter int WIDTH    = 16,
  parameter int DUTY_MAX = 60000,
  parameter int STEP     = 100,
  parameter int TICK_DIV = 240000,
  parameter int TICK_W   = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_tgt_duty,
  input  logic             i_tgt_valid,
  output logic             o_tgt_ready,
  input  logic             i_estop,
`ifdef DUTY_RAMP_BYPASS_EN
  input  logic             i_bypass,
`endif
  output logic [WIDTH-1:0] o_pwm_duty,
  output logic             o_pwm_wen,
  output logic             o_busy,
  output logic [1:0]       o_state
);

  localparam logic [1:0]        S_IDLE  = 2'd0;
  localparam logic [1:0]        S_RAMP  = 2'd1;
  localparam logic [1:0]        S_WRITE = 2'd2;
  localparam logic [WIDTH-1:0]  DMAX_N  = WIDTH'(DUTY_MAX);
  localparam logic [WIDTH-1:0]  STEP_N  = WIDTH'(STEP);
  localparam logic [WIDTH:0]    STEP_W  = (WIDTH+1)'(STEP);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_cur, r_tgt, r_nxt;
  logic [TICK_W-1:0] r_tick;
  logic              r_wen, r_busy;

  logic [WIDTH-1:0]  w_cur_d, w_tgt_d, w_nxt_d;
  logic [TICK_W-1:0] w_tick_d;
  logic              w_wen_d;

  logic [WIDTH-1:0]  w_clamp, w_tgt_eff, w_delta, w_step_nxt;
  logic [WIDTH:0]    w_diff;
  logic              w_ready, w_accept, w_byp, w_up, w_tick_end;
  logic              w_estop_idle0, w_estop_commit;

  // Handshake: a target transfers on any cycle where i_tgt_valid and o_tgt_ready are both high.
  assign w_ready     = ~i_rst & ~i_estop & ((r_state == S_IDLE) | (r_state == S_RAMP));
  assign o_tgt_ready = w_ready;
  assign w_accept    = i_tgt_valid & w_ready;
`ifdef DUTY_RAMP_BYPASS_EN
  assign w_byp = i_bypass;
`else
  assign w_byp = 1'b0;
`endif

  assign w_clamp    = (i_tgt_duty > DMAX_N) ? DMAX_N : i_tgt_duty;
  assign w_tgt_eff  = w_accept ? w_clamp : r_tgt;
  assign w_tick_end = (r_tick == TICK_LAST);
  assign w_up       = (w_tgt_eff > r_cur);
  assign w_diff     = w_up ? ({1'b0, w_tgt_eff} - {1'b0, r_cur})
                           : ({1'b0, r_cur} - {1'b0, w_tgt_eff});
  assign w_delta    = (w_diff > STEP_W) ? STEP_N : w_diff[WIDTH-1:0];
  assign w_step_nxt = w_up ? (r_cur + w_delta) : (r_cur - w_delta);

  // Estop with nothing to undo stays quiet; estop arriving while a zero is already pending commits it.
  assign w_estop_idle0  = (r_state == S_IDLE) && (r_cur == '0);
  assign w_estop_commit = (r_state == S_WRITE) && (r_nxt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_estop) begin
      if (w_estop_idle0 || w_estop_commit) w_state_nxt = S_IDLE;
      else                                 w_state_nxt = S_WRITE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_byp)             w_state_nxt = S_WRITE;
          else if (w_accept && w_clamp != r_cur) w_state_nxt = S_RAMP;
        end
        S_RAMP: begin
          if (w_accept && w_byp)                  w_state_nxt = S_WRITE;
          else if (w_accept && w_clamp == r_cur)  w_state_nxt = S_IDLE;
          else if (w_tick_end)                    w_state_nxt = S_WRITE;
        end
        S_WRITE: w_state_nxt = (r_nxt == r_tgt) ? S_IDLE : S_RAMP;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The strobe and new duty are registered on the edge that leaves WRITE.
  always_comb begin
    w_cur_d  = r_cur;
    w_tgt_d  = r_tgt;
    w_nxt_d  = r_nxt;
    w_tick_d = r_tick;
    w_wen_d  = 1'b0;
    if (i_estop) begin
      w_tgt_d  = '0;
      w_tick_d = '0;
      w_nxt_d  = '0;
      if (w_estop_commit) begin
        w_cur_d = '0;
        w_wen_d = 1'b1;
      end
    end else begin
      if (w_accept) w_tgt_d = w_clamp;
      case (r_state)
        S_IDLE: begin
          if (w_accept) w_tick_d = '0;
          if (w_accept && w_byp) w_nxt_d = w_clamp;
        end
        S_RAMP: begin
          if (w_accept && w_byp) begin
            w_nxt_d  = w_clamp;
            w_tick_d = '0;
          end else if (w_accept && w_clamp == r_cur) begin
            w_tick_d = '0;
          end else if (w_tick_end) begin
            w_tick_d = '0;
            w_nxt_d  = w_step_nxt;
          end else begin
            w_tick_d = r_tick + TICK_W'(1);
          end
        end
        S_WRITE: begin
          w_cur_d  = r_nxt;
          w_wen_d  = 1'b1;
          w_tick_d = '0;
        end
        default: w_tick_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur  <= '0;
      r_tgt  <= '0;
      r_nxt  <= '0;
      r_tick <= '0;
      r_wen  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_cur  <= w_cur_d;
      r_tgt  <= w_tgt_d;
      r_nxt  <= w_nxt_d;
      r_tick <= w_tick_d;
      r_wen  <= w_wen_d;
      r_busy <= (r_state != S_IDLE);
    end
  end

  assign o_pwm_duty = r_cur;
  assign o_pwm_wen  = r_wen;
  assign o_busy     = r_busy;
  assign o_state    = r_state;

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp: instance a (STEP=100) and instance b (STEP=30000), both TICK_DIV=10.
module tb_duty_ramp;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_tgt_duty, b_tgt_duty;
  logic        a_tgt_valid, b_tgt_valid, a_estop, b_estop;
  logic        a_tgt_ready, b_tgt_ready, a_pwm_wen, b_pwm_wen, a_busy, b_busy;
  logic [15:0] a_pwm_duty, b_pwm_duty;
  logic [1:0]  a_state, b_state;
`ifdef DUTY_RAMP_BYPASS_EN
  logic        a_bypass, b_bypass;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  duty_ramp #(.WIDTH(16), .DUTY_MAX(60000), .STEP(100), .TICK_DIV(10), .TICK_W(18)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tgt_duty(a_tgt_duty), .i_tgt_valid(a_tgt_valid),
    .o_tgt_ready(a_tgt_ready), .i_estop(a_estop),
`ifdef DUTY_RAMP_BYPASS_EN
    .i_bypass(a_bypass),
`endif
    .o_pwm_duty(a_pwm_duty), .o_pwm_wen(a_pwm_wen), .o_busy(a_busy), .o_state(a_state));

  duty_ramp #(.WIDTH(16), .DUTY_MAX(60000), .STEP(30000), .TICK_DIV(10), .TICK_W(18)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tgt_duty(b_tgt_duty), .i_tgt_valid(b_tgt_valid),
    .o_tgt_ready(b_tgt_ready), .i_estop(b_estop),
`ifdef DUTY_RAMP_BYPASS_EN
    .i_bypass(b_bypass),
`endif
    .o_pwm_duty(b_pwm_duty), .o_pwm_wen(b_pwm_wen), .o_busy(b_busy), .o_state(b_state));

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  // Advances until a write strobe is seen; n = edges waited, or -1 if the bound expired.
  task automatic wait_write(input bit use_b, input int bound, output int n, output logic [15:0] val);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < bound) begin
      @(posedge clk);
      #1;
      n++;
      seen = use_b ? b_pwm_wen : a_pwm_wen;
    end
    val = use_b ? b_pwm_duty : a_pwm_duty;
    if (!seen) n = -1;
  endtask

  task automatic accept_a(input logic [15:0] v, input bit byp);
    a_tgt_duty  = v;
    a_tgt_valid = 1'b1;
`ifdef DUTY_RAMP_BYPASS_EN
    a_bypass = byp;
`else
    if (byp) $display("note: bypass ignored in this build");
`endif
    cycles(1);
    a_tgt_valid = 1'b0;
`ifdef DUTY_RAMP_BYPASS_EN
    a_bypass = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_tgt_valid = 1'b1;
    cycles(2);
    total++; if (a_tgt_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", a_tgt_ready); end
    total++; if (a_pwm_duty !== 16'd0) begin bad++; $display("FAIL reset_duty: got %0d want 0", a_pwm_duty); end
    total++; if (a_pwm_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %0b want 0", a_pwm_wen); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", a_busy); end
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", a_state); end
    a_tgt_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (a_tgt_ready !== 1'b1) begin bad++; $display("FAIL idle_ready: got %0b want 1", a_tgt_ready); end
  endtask

  task automatic test_ramp_up();
    logic [15:0] exp_v [3] = '{16'd100, 16'd200, 16'd250};
    int n;
    logic [15:0] v;
    accept_a(16'd250, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_write(1'b0, 40, n, v);
      total++; if (n !== 11) begin bad++; $display("FAIL up_gap%0d: got %0d want 11", i, n); end
      total++; if (v !== exp_v[i]) begin bad++; $display("FAIL up_val%0d: got %0d want %0d", i, v, exp_v[i]); end
    end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL up_busy_at_last: got %0b want 1", a_busy); end
    cycles(1);
    total++; if (a_pwm_wen !== 1'b0) begin bad++; $display("FAIL up_wen_single: got %0b want 0", a_pwm_wen); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL up_busy_fall: got %0b want 0", a_busy); end
  endtask

  task automatic test_ramp_down();
    logic [15:0] exp_v [3] = '{16'd150, 16'd50, 16'd0};
    int n;
    logic [15:0] v;
    accept_a(16'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_write(1'b0, 40, n, v);
      total++; if (n !== 11) begin bad++; $display("FAIL down_gap%0d: got %0d want 11", i, n); end
      total++; if (v !== exp_v[i]) begin bad++; $display("FAIL down_val%0d: got %0d want %0d", i, v, exp_v[i]); end
    end
    cycles(1);
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL down_idle: got %0d want 0", a_state); end
    total++; if (a_pwm_duty !== 16'd0) begin bad++; $display("FAIL down_final: got %0d want 0", a_pwm_duty); end
  endtask

  task automatic test_clamp();
    logic [15:0] exp_v [2] = '{16'd30000, 16'd60000};
    int n;
    logic [15:0] v;
    b_tgt_duty  = 16'd65535;
    b_tgt_valid = 1'b1;
    cycles(1);
    b_tgt_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_write(1'b1, 40, n, v);
      total++; if (n !== 11) begin bad++; $display("FAIL clamp_gap%0d: got %0d want 11", i, n); end
      total++; if (v !== exp_v[i]) begin bad++; $display("FAIL clamp_val%0d: got %0d want %0d", i, v, exp_v[i]); end
    end
    wait_write(1'b1, 25, n, v);
    total++; if (n !== -1) begin bad++; $display("FAIL clamp_extra_write: got gap %0d want none", n); end
    total++; if (b_pwm_duty !== 16'd60000) begin bad++; $display("FAIL clamp_hold: got %0d want 60000", b_pwm_duty); end
  endtask

  task automatic test_retarget();
    int n;
    logic [15:0] v;
    accept_a(16'd1000, 1'b0);
    wait_write(1'b0, 40, n, v);
    wait_write(1'b0, 40, n, v);
    total++; if (v !== 16'd200) begin bad++; $display("FAIL rt_pre: got %0d want 200", v); end
    cycles(3);
    accept_a(16'd200, 1'b0);
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL rt_same_idle: got %0d want 0", a_state); end
    wait_write(1'b0, 20, n, v);
    total++; if (n !== -1) begin bad++; $display("FAIL rt_same_nowrite: got gap %0d want none", n); end
    accept_a(16'd1000, 1'b0);
    cycles(3);
    accept_a(16'd120, 1'b0);
    wait_write(1'b0, 20, n, v);
    total++; if (n !== 7) begin bad++; $display("FAIL rt_gap: got %0d want 7", n); end
    total++; if (v !== 16'd120) begin bad++; $display("FAIL rt_val: got %0d want 120", v); end
    cycles(1);
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL rt_idle: got %0d want 0", a_state); end
  endtask

  task automatic test_estop();
    int n;
    logic [15:0] v;
    do_reset();
    accept_a(16'd1000, 1'b0);
    repeat (3) wait_write(1'b0, 40, n, v);
    total++; if (v !== 16'd300) begin bad++; $display("FAIL es_pre: got %0d want 300", v); end
    cycles(2);
    a_estop = 1'b1;
    #1;
    total++; if (a_tgt_ready !== 1'b0) begin bad++; $display("FAIL es_ready: got %0b want 0", a_tgt_ready); end
    @(posedge clk);
    #1;
    a_estop = 1'b0;
    total++; if (a_state !== ST_WRITE) begin bad++; $display("FAIL es_state: got %0d want 2", a_state); end
    wait_write(1'b0, 5, n, v);
    total++; if (n !== 1) begin bad++; $display("FAIL es_gap: got %0d want 1", n); end
    total++; if (v !== 16'd0) begin bad++; $display("FAIL es_val: got %0d want 0", v); end
    total++; if (a_state !== ST_IDLE) begin bad++; $display("FAIL es_idle: got %0d want 0", a_state); end
    wait_write(1'b0, 15, n, v);
    total++; if (n !== -1) begin bad++; $display("FAIL es_after: got gap %0d want none", n); end
    a_estop = 1'b1;
    wait_write(1'b0, 6, n, v);
    total++; if (n !== -1) begin bad++; $display("FAIL es_held_zero: got gap %0d want none", n); end
    a_estop = 1'b0;
  endtask

  task automatic test_reset_midramp();
    int n;
    logic [15:0] v;
    do_reset();
    accept_a(16'd1000, 1'b0);
    repeat (2) wait_write(1'b0, 40, n, v);
    total++; if (v !== 16'd200) begin bad++; $display("FAIL rr_pre: got %0d want 200", v); end
    cycles(3);
    do_reset();
    total++; if (a_pwm_duty !== 16'd0) begin bad++; $display("FAIL rr_duty: got %0d want 0", a_pwm_duty); end
    total++; if (a_pwm_wen !== 1'b0) begin bad++; $display("FAIL rr_wen: got %0b want 0", a_pwm_wen); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rr_busy: got %0b want 0", a_busy); end
    wait_write(1'b0, 15, n, v);
    total++; if (n !== -1) begin bad++; $display("FAIL rr_nowrite: got gap %0d want none", n); end
  endtask

`ifdef DUTY_RAMP_BYPASS_EN
  task automatic test_bypass();
    int n;
    logic [15:0] v;
    accept_a(16'd500, 1'b1);
    total++; if (a_state !== ST_WRITE) begin bad++; $display("FAIL byp_state: got %0d want 2", a_state); end
    wait_write(1'b0, 5, n, v);
    total++; if (n !== 1) begin bad++; $display("FAIL byp_gap: got %0d want 1", n); end
    total++; if (v !== 16'd500) begin bad++; $display("FAIL byp_val: got %0d want 500", v); end
    wait_write(1'b0, 15, n, v);
    total++; if (n !== -1) begin bad++; $display("FAIL byp_single: got gap %0d want none", n); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_tgt_duty = '0; a_tgt_valid = 1'b0; a_estop = 1'b0;
    b_tgt_duty = '0; b_tgt_valid = 1'b0; b_estop = 1'b0;
`ifdef DUTY_RAMP_BYPASS_EN
    a_bypass = 1'b0; b_bypass = 1'b0;
`endif
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_retarget();
    test_estop();
    test_reset_midramp();
`ifdef DUTY_RAMP_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
